slot_reels: RTL

Reel generator for the slot-machine datapath. It sits directly upstream of the balance/bank stage and produces the four decimal reel digits that stage compares for a jackpot. A debounced spin button starts a spin. All four reels cycle pseudo-randomly and then stop one at a time. A single-cycle `result_valid` pulse marks the moment the four digits are final.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/slot_lfsr16.sv | 20 ++
 rtl/slot_reels.sv | 107 ++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine reel generator.
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int              DIGIT_W           = 4;
  localparam logic [3:0]      DIGIT_MAX         = 4'd9;
  localparam logic [15:0]     LFSR_TAPS         = 16'hB400;
  localparam logic [15:0]     LFSR_SEED_DEFAULT = 16'hACE1;

  // Nibbles 10..15 fold back onto 0..5, so every reel shows a decimal digit.
  function automatic logic [DIGIT_W-1:0] to_digit(input logic [3:0] nib);
    return (nib > DIGIT_MAX) ? nib - 4'd10 : nib;
  endfunction

endpackage

// File: rtl/slot_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
module slot_lfsr16
  import slot_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/slot_reels.sv
// Four-reel generator: a spin edge starts all reels cycling, then they freeze
// one by one and result_valid strobes once the last digit is final.
module slot_reels
  import slot_pkg::*;
#(
  parameter int unsigned SPIN_TICKS    = 50_000_000,
  parameter int unsigned STAGGER_TICKS = 25_000_000,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin,
  output logic [3:0] randNum1,
  output logic [3:0] randNum2,
  output logic [3:0] randNum3,
  output logic [3:0] randNum4,
  output logic       spinning,
  output logic       result_valid
);

  // result_valid is a one-cycle strobe with no ready/backpressure: the digits
  // are guaranteed final only in the cycle it is high, and they then hold until
  // the next spin edge is accepted.

  state_t                    state, state_next;
  logic [31:0]               cnt, cnt_next;
  logic [3:0]                running, running_next;
  logic [3:0][DIGIT_W-1:0]   reel, reel_next, digit;
  logic [15:0]               lfsr_value;
  logic                      spin_q;
  logic                      spin_event;

  function automatic logic [31:0] freeze_at(input int unsigned k);
    return 32'(SPIN_TICKS + k * STAGGER_TICKS - 1);
  endfunction

  slot_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign spin_event = spin & ~spin_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      digit[k] = to_digit(lfsr_value[4*k +: 4]);
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    running_next = running;
    reel_next    = reel;
    case (state)
      IDLE: begin
        if (spin_event) begin
          state_next   = SPIN;
          cnt_next     = 32'd0;
          running_next = 4'b1111;
        end
      end
      SPIN: begin
        cnt_next = cnt + 32'd1;
        for (int k = 0; k < 4; k++) begin
          if (running[k]) begin
            reel_next[k] = digit[k];
            if (cnt == freeze_at(k)) running_next[k] = 1'b0;
          end
        end
        // Reel 4 always freezes last, so its freeze ends the spin.
        if (running[3] && (cnt == freeze_at(3))) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      running      <= 4'b0000;
      reel         <= '0;
      spin_q       <= 1'b1;
      spinning     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      running      <= running_next;
      reel         <= reel_next;
      spin_q       <= spin;
      spinning     <= (state_next == SPIN);
      result_valid <= (state_next == DONE);
    end
  end

  assign randNum1 = reel[0];
  assign randNum2 = reel[1];
  assign randNum3 = reel[2];
  assign randNum4 = reel[3];

endmodule
